// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver
//   Multiplexed 4-digit common-anode seven-segment driver. Each digit is lit
//   for CLK_DIV clocks, followed by GAP_CYCLES clocks with every anode off to
//   suppress ghosting. A new value is double-buffered (pending -> shadow) and
//   only reaches the display at a frame boundary, so a frame never tears.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-low
//   value[15:0]  hex value to display, digit 0 = value[3:0] (rightmost)
//   load         one-clock strobe, captures value into pending
//   lz_suppress  1 = blank leading zero digits (digit 0 always shown)
//   blank        1 = all digits dark, scanning continues
//   seg[6:0]     segments {g,f,e,d,c,b,a}, a = bit 0
//   an[3:0]      digit enables, an[i] lights digit i
//   frame_tick   one-clock pulse in the cycle after the frame-boundary edge
//
// state | meaning
// SHOW  | digit d lit (unless blanked) for CLK_DIV clocks
// GAP   | all anodes off for GAP_CYCLES clocks, then advance d
module sevenseg_scan_driver #(
  parameter int CLK_DIV    = 25000,
  parameter int GAP_CYCLES = 500,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        lz_suppress,
  input  logic        blank,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'hF  : 4'h0;

  typedef enum logic {
    SHOW = 1'b0,
    GAP  = 1'b1
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       d_q;
  logic [15:0]      pending_q;
  logic [15:0]      shadow_q;
  logic [6:0]       seg_q;
  logic [3:0]       an_q;
  logic             frame_tick_q;

  logic [3:0]       nib;
  logic [6:0]       hex;
  logic             upper_zero;
  logic             blanked;
  logic [6:0]       seg_d;
  logic [3:0]       an_d;

  assign nib = shadow_q[{d_q, 2'b00} +: 4];

  always_comb begin
    hex = 7'h00;
    case (nib)
      4'h0: hex = 7'h3F;
      4'h1: hex = 7'h06;
      4'h2: hex = 7'h5B;
      4'h3: hex = 7'h4F;
      4'h4: hex = 7'h66;
      4'h5: hex = 7'h6D;
      4'h6: hex = 7'h7D;
      4'h7: hex = 7'h07;
      4'h8: hex = 7'h7F;
      4'h9: hex = 7'h6F;
      4'hA: hex = 7'h77;
      4'hB: hex = 7'h7C;
      4'hC: hex = 7'h39;
      4'hD: hex = 7'h5E;
      4'hE: hex = 7'h79;
      4'hF: hex = 7'h71;
      default: hex = 7'h00;
    endcase
  end

  // Digit d is a leading zero when it and every digit above it are zero.
  always_comb begin
    upper_zero = 1'b0;
    case (d_q)
      2'd1: upper_zero = (shadow_q[15:4] == 12'h000);
      2'd2: upper_zero = (shadow_q[15:8] == 8'h00);
      2'd3: upper_zero = (shadow_q[15:12] == 4'h0);
      default: upper_zero = 1'b0;
    endcase
  end

  assign blanked = blank | (lz_suppress & upper_zero);

  always_comb begin
    seg_d = SEG_OFF;
    an_d  = AN_OFF;
    if (state_q == SHOW && !blanked) begin
      seg_d = ACTIVE_LOW ? ~hex : hex;
      an_d  = ACTIVE_LOW ? ~(4'b0001 << d_q) : (4'b0001 << d_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= SHOW;
      cnt_q        <= '0;
      d_q          <= 2'd0;
      pending_q    <= 16'h0000;
      shadow_q     <= 16'h0000;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= 1'b0;
      seg_q        <= seg_d;
      an_q         <= an_d;
      if (load) pending_q <= value;
      case (state_q)
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_q <= GAP;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_q <= SHOW;
            cnt_q   <= '0;
            d_q     <= d_q + 2'd1;
            if (d_q == 2'd3) begin
              // A load on the boundary edge bypasses pending so it is not
              // delayed by a whole frame.
              shadow_q     <= load ? value : pending_q;
              frame_tick_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= SHOW;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule
